// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller between the CPU memory-access stage and a word-mode
// data RAM. Byte and halfword stores are read-modify-write sequences, so the
// other bytes of the addressed word are preserved. Loads extract the
// addressed byte or halfword lane and sign- or zero-extend it. Misaligned
// accesses and the illegal size encoding complete with an error and do not
// touch the RAM.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req_valid/ready   CPU request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      1 = zero-extend load, 0 = sign-extend load
//   done              one-cycle completion pulse
//   rdata             load result, valid with done (0 for stores/errors)
//   err               valid with done, misaligned or illegal size
//   mem_we            RAM write enable (one cycle per store)
//   mem_addr          word-aligned RAM address
//   mem_wData         merged RAM write word
//   mem_rData         RAM combinational read data
//   mem_LSControl     RAM access mode, fixed to word
//   mem_SignControl   RAM sign control, fixed to 0
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,

    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wData,
    input  logic [31:0]       mem_rData,
    output logic [1:0]        mem_LSControl,
    output logic              mem_SignControl
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              we_q;
    logic              err_q;
    logic [31:0]       word_q;

    logic accept;
    logic req_bad;
    logic req_word_store;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    assign accept = req_valid && (state_q == StIdle);

    always_comb begin
        req_bad = 1'b0;
        unique case (req_size)
            SizeByte: req_bad = 1'b0;
            SizeHalf: req_bad = req_addr[0];
            SizeWord: req_bad = (req_addr[1:0] != 2'b00);
            default:  req_bad = 1'b1;
        endcase
    end

    // An aligned word store overwrites the whole word, so no read is needed.
    assign req_word_store = req_we && (req_size == SizeWord);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = StResp;
                    end else if (req_word_store) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = we_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // Request and read-data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            we_q       <= req_we;
            err_q      <= req_bad;
        end
    end

    // The RAM read path terminates here; nothing downstream sees mem_rData
    // combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
        end else if (state_q == StRd) begin
            word_q <= mem_rData;
        end
    end

    // -----------------------------------------------------------------------
    // Store merge and load extraction
    // -----------------------------------------------------------------------
    logic [31:0] merged_word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_word;

    always_comb begin
        merged_word = word_q;
        unique case (size_q)
            SizeByte: merged_word[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            SizeHalf: merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default:  merged_word = wdata_q;
        endcase
    end

    assign byte_lane = word_q[{addr_q[1:0], 3'b000} +: 8];
    assign half_lane = word_q[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_word = word_q;
        unique case (size_q)
            SizeByte: load_word = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            SizeHalf: load_word = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default:  load_word = word_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (state-decoded only, no path from req_*)
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rdata     = '0;
        mem_we    = 1'b0;
        mem_wData = '0;
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StRd:   ;
            StWr: begin
                mem_we    = 1'b1;
                mem_wData = merged_word;
            end
            StResp: begin
                done = 1'b1;
                err  = err_q;
                if (!we_q && !err_q) begin
                    rdata = load_word;
                end
            end
            default: ;
        endcase
    end

    assign mem_addr        = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_LSControl   = 2'b10;
    assign mem_SignControl = 1'b0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Directed bench for lsu_mem_ctrl with a small word-mode RAM model. Each
// access records the cycle (counted from the accepting edge) at which done
// rises, the load result, the error flag and every RAM write seen on the way.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wData;
    logic [31:0] mem_rData;
    logic [1:0]  mem_LSControl;
    logic        mem_SignControl;

    int n_checks = 0;
    int n_fail   = 0;

    // Result of the latest access
    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_we_cnt;
    int          r_we_at;
    logic [31:0] r_we_data;
    logic [31:0] r_we_addr;
    int          r_busy_ready;

    logic [31:0] ram [0:15];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(
        .ADDR_W(32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .done            (done),
        .rdata           (rdata),
        .err             (err),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wData       (mem_wData),
        .mem_rData       (mem_rData),
        .mem_LSControl   (mem_LSControl),
        .mem_SignControl (mem_SignControl)
    );

    // Word-mode RAM: combinational read, write on the rising edge
    assign mem_rData = ram[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[5:2]] <= mem_wData;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and follow it until done (bounded).
    task automatic run_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input logic uns, input bit hold);
        r_lat        = 0;
        r_rdata      = 'x;
        r_err        = 1'bx;
        r_we_cnt     = 0;
        r_we_at      = 0;
        r_we_data    = '0;
        r_we_addr    = '0;
        r_busy_ready = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        // Request inputs are free to change once accepted
        req_we       = ~we;
        req_addr     = 32'h0000_0007;
        req_wdata    = 32'hFFFF_FFFF;
        req_size     = 2'b11;
        req_unsigned = ~uns;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) begin
                r_we_cnt++;
                r_we_at   = k;
                r_we_data = mem_wData;
                r_we_addr = mem_addr;
            end
            if (!done && req_ready) r_busy_ready++;
            if (done) begin
                r_lat   = k;
                r_rdata = rdata;
                r_err   = err;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input int lat, input logic [31:0] rd,
                               input logic e, input int wcnt, input int wat,
                               input logic [31:0] wdat, input logic [31:0] waddr);
        check({tag, " latency"}, 32'(r_lat), 32'(lat));
        check({tag, " rdata"}, r_rdata, rd);
        check({tag, " err"}, {31'b0, r_err}, {31'b0, e});
        check({tag, " mem_we pulses"}, 32'(r_we_cnt), 32'(wcnt));
        check({tag, " ready while busy"}, 32'(r_busy_ready), 32'd0);
        if (wcnt > 0) begin
            check({tag, " write cycle"}, 32'(r_we_at), 32'(wat));
            check({tag, " write data"}, r_we_data, wdat);
            check({tag, " write addr"}, r_we_addr, waddr);
        end
    endtask

    initial begin
        int we_seen;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        ram[4] = 32'h8899_AABB;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = '0;
        req_unsigned = 1'b0;

        #1;
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset err", {31'b0, err}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset mem_we", {31'b0, mem_we}, 32'd0);
        check("reset mem_wData", mem_wData, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("LSControl", {30'b0, mem_LSControl}, 32'd2);
        check("SignControl", {31'b0, mem_SignControl}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Loads from 0x10 = 0x8899AABB
        run_access(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b0);
        expect_resp("LB 0x13", 2, 32'hFFFF_FF88, 1'b0, 0, 0, 0, 0);
        run_access(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 1'b0);
        expect_resp("LBU 0x13", 2, 32'h0000_0088, 1'b0, 0, 0, 0, 0);
        run_access(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 1'b0);
        expect_resp("LH 0x12", 2, 32'hFFFF_8899, 1'b0, 0, 0, 0, 0);
        run_access(1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 1'b0);
        expect_resp("LHU 0x10", 2, 32'h0000_AABB, 1'b0, 0, 0, 0, 0);
        run_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_resp("LW 0x10", 2, 32'h8899_AABB, 1'b0, 0, 0, 0, 0);

        // Byte store, then read back
        run_access(1'b1, 32'h11, 32'h1234_5677, 2'b00, 1'b0, 1'b0);
        expect_resp("SB 0x11", 3, 32'h0, 1'b0, 1, 2, 32'h8899_77BB, 32'h10);
        run_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_resp("LW after SB", 2, 32'h8899_77BB, 1'b0, 0, 0, 0, 0);
        run_access(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 1'b0);
        expect_resp("LB 0x11 positive", 2, 32'h0000_0077, 1'b0, 0, 0, 0, 0);

        // Half store, then read back
        run_access(1'b1, 32'h12, 32'h0000_CAFE, 2'b01, 1'b0, 1'b0);
        expect_resp("SH 0x12", 3, 32'h0, 1'b0, 1, 2, 32'hCAFE_77BB, 32'h10);
        run_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_resp("LW after SH", 2, 32'hCAFE_77BB, 1'b0, 0, 0, 0, 0);

        // Word store skips the read
        run_access(1'b1, 32'h14, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0);
        expect_resp("SW 0x14", 2, 32'h0, 1'b0, 1, 1, 32'hDEAD_BEEF, 32'h14);
        run_access(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_resp("LW 0x14", 2, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, 0);

        // Error cases
        run_access(1'b0, 32'h16, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_resp("LW 0x16 misaligned", 1, 32'h0, 1'b1, 0, 0, 0, 0);
        run_access(1'b1, 32'h11, 32'h0000_1111, 2'b01, 1'b0, 1'b0);
        expect_resp("SH 0x11 misaligned", 1, 32'h0, 1'b1, 0, 0, 0, 0);
        run_access(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 1'b0);
        expect_resp("size 11", 1, 32'h0, 1'b1, 0, 0, 0, 0);
        check("RAM 0x10 after errors", ram[4], 32'hCAFE_77BB);

        // req_valid held high across a busy access is taken only once
        run_access(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 1'b1);
        expect_resp("LHU 0x12 held", 2, 32'h0000_CAFE, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        check("held: idle after done", {31'b0, req_ready}, 32'd1);
        check("held: no second done", {31'b0, done}, 32'd0);

        // Reset during the read phase of a byte store
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0000_0055;
        req_size  = 2'b00;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("SB in RD: ready low", {31'b0, req_ready}, 32'd0);
        we_seen = mem_we ? 1 : 0;
        reset = 1'b1;
        #1;
        check("rst mid: done", {31'b0, done}, 32'd0);
        check("rst mid: err", {31'b0, err}, 32'd0);
        check("rst mid: rdata", rdata, 32'd0);
        check("rst mid: mem_we", {31'b0, mem_we}, 32'd0);
        check("rst mid: mem_wData", mem_wData, 32'd0);
        check("rst mid: req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        if (mem_we) we_seen++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
        end
        check("rst mid: no RAM write", 32'(we_seen), 32'd0);
        check("rst mid: RAM word kept", ram[4], 32'hCAFE_77BB);

        run_access(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 1'b0);
        expect_resp("LB 0x10 after reset", 2, 32'hFFFF_FFBB, 1'b0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
